tdc_core: RTL



---
 rtl/tdc_core_if.sv | 21 ++
 rtl/tdc_core.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/tdc_core_if.sv
// AXI-Stream record channel for tdc_core.
// tdata/tvalid flow master->slave, tready flows back.
interface tdc_core_if #(
  parameter int DATA_WIDTH = 97
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/tdc_core.sv
// Time-to-digital converter: one record per S0 gate interval.
// Ports: i_clk, i_rst (sync high), i_en, i_s[1:0], m_axis, o_overrun.
module tdc_core #(
  parameter int COUNTER_WIDTH = 32,
  parameter int DATA_WIDTH    = 1 + 3 * COUNTER_WIDTH
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_s,
  tdc_core_if.master m_axis,
  output logic       o_overrun
);
  localparam int W = COUNTER_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_A,
    WAIT_B,
    DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0] cnt0, cnt1;
  logic [W-1:0] t1_q, t2_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic valid_q, ovr_q;

  logic s0, s1;
  logic in_gate;
  logic open_gate;
  logic close_gate;

  function automatic logic [W-1:0] sat_inc(
    input logic [W-1:0] v
  );
    return (v == '1) ? v : v + ONE;
  endfunction

  assign s0 = i_s[0];
  assign s1 = i_s[1];

  assign in_gate = (state == WAIT_A) ||
                   (state == WAIT_B) ||
                   (state == DONE);

  // Any S0 outside IDLE starts a new interval;
  // only one inside an interval closes a record.
  assign open_gate  = i_en && s0 &&
                      (state != IDLE);
  assign close_gate = i_en && s0 && in_gate;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!i_en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: state_n = ARM;
        ARM,
        WAIT_A,
        WAIT_B,
        DONE: begin
          // S0 wins; a same-cycle S1 is the
          // first S1 of the new interval.
          if (s0) begin
            state_n = s1 ? WAIT_B : WAIT_A;
          end else if (s1) begin
            if (state == WAIT_A)
              state_n = WAIT_B;
            else if (state == WAIT_B)
              state_n = DONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      cnt0 <= '0;
      cnt1 <= '0;
      t1_q <= '0;
      t2_q <= '0;
    end else if (open_gate) begin
      cnt0 <= ONE;
      t1_q <= '0;
      t2_q <= '0;
      cnt1 <= s1 ? ONE : '0;
    end else begin
      if (in_gate)
        cnt0 <= sat_inc(cnt0);
      if (state == WAIT_B)
        cnt1 <= sat_inc(cnt1);
      if (state == WAIT_A && s1) begin
        t1_q <= cnt0;
        cnt1 <= ONE;
      end
      if (state == WAIT_B && s1)
        t2_q <= cnt1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (!i_en)
        ovr_q <= 1'b0;
      if (close_gate) begin
        if (!valid_q || m_axis.tready) begin
          data_q  <= DATA_WIDTH'({
            (state == DONE), t2_q, t1_q, cnt0
          });
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && m_axis.tready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign o_overrun     = ovr_q;
endmodule
